// File: rtl/uart_fifo_tx.sv
// UART 8N1 transmitter popping bytes from a show-ahead FIFO; frame lasts 10*CLKS_PER_BIT cycles, plus one IDLE cycle between frames.
// Pops only in IDLE when the FIFO is non-empty. Define UART_TX_PARITY_EN to add an even-parity bit (11*CLKS_PER_BIT frame).
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_BITS     = $clog2(CLKS_PER_BIT) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CLKS_PER_BIT - 1);

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic [2:0]          bit_idx, bit_idx_nxt;
  logic [7:0]          shift, shift_nxt;
  logic                bit_end;
  logic                tx_d, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                parity, parity_nxt;
`endif

  assign bit_end    = (cnt == CNT_LAST);
  assign fifo_rd_en = (state == IDLE) && !fifo_empty && !rst;
  assign tx_done    = (state == STOP) && bit_end && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_d;
      busy    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_end ? '0 : cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
`ifdef UART_TX_PARITY_EN
    parity_nxt  = parity;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fifo_rd_en) begin
          shift_nxt = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
          // parity taken from the captured byte, before any shifting
          parity_nxt = ^fifo_rd_data;
`endif
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            shift_nxt   = {1'b0, shift[7:1]};
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP: if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx/busy are registered from the next-state view so they line up with state
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_nxt != IDLE);
    case (state_nxt)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_nxt;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: two instances (CLKS_PER_BIT=4 and 1) fed by queue FIFOs,
// observed traces compared cycle by cycle against a frame-arithmetic model.
module tb_uart_fifo_tx;

  typedef logic [7:0] bq_t[$];

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       e4, e1;
  logic [7:0] d4, d1;
  logic       rd4, tx4, busy4, done4;
  logic       rd1, tx1, busy1, done1;

  bq_t        fifo4, fifo1;
  logic [3:0] obs[$];
  logic       pend4, pend1;
  int         pops4, pops1;
  int         n_checks, n_fail;

  always #5 clk = ~clk;

  uart_fifo_tx #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst(rst), .fifo_empty(e4), .fifo_rd_data(d4),
    .fifo_rd_en(rd4), .tx(tx4), .busy(busy4), .tx_done(done4));

  uart_fifo_tx #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst(rst), .fifo_empty(e1), .fifo_rd_data(d1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1));

  // ---------------- reference model ----------------
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    logic [7:0] v;
    v = b;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return v[3'(slot - 1)];
    if (NB == 11 && slot == 9) return ^v;
    return 1'b1;
  endfunction

  // expected {rd_en, busy, tx, tx_done} at cycle c when bytes are queued at c=0
  function automatic logic [3:0] model_at(input bq_t bytes, input int cpb, input int c);
    int f, j, m;
    f = NB * cpb;
    j = c / (f + 1);
    m = c % (f + 1);
    if (j >= bytes.size()) return 4'b0010;
    if (m == 0) return 4'b1010;
    return {1'b0, 1'b1, frame_bit(bytes[j], (m - 1) / cpb), 1'(m == f)};
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic drive_fifo();
    e4 = (fifo4.size() == 0);
    d4 = e4 ? 8'h00 : fifo4[0];
    e1 = (fifo1.size() == 0);
    d1 = e1 ? 8'h00 : fifo1[0];
  endtask

  // runs ncyc cycles, pops the model FIFOs where the DUT popped, records one instance
  task automatic capture(input int sel, input int ncyc, input int rst_at);
    obs.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (pend4) begin void'(fifo4.pop_front()); pops4++; end
      if (pend1) begin void'(fifo1.pop_front()); pops1++; end
      rst = (c == rst_at);
      drive_fifo();
      #1;
      obs.push_back(sel == 0 ? {rd4, busy4, tx4, done4} : {rd1, busy1, tx1, done1});
      pend4 = rd4;
      pend1 = rd1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_fifo();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({rd4, busy4, tx4, done4} !== 4'b0010) begin
      n_fail++; $display("FAIL reset_u4: got %b want 0010", {rd4, busy4, tx4, done4});
    end
    n_checks++;
    if ({rd1, busy1, tx1, done1} !== 4'b0010) begin
      n_fail++; $display("FAIL reset_u1: got %b want 0010", {rd1, busy1, tx1, done1});
    end
    fifo4.push_back(8'h77);
    drive_fifo();
    #1;
    n_checks++;
    if (rd4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_pop: rd_en got %b want 0", rd4);
    end
    fifo4.delete();
    drive_fifo();
    capture(0, 200, -1);
    for (int c = 0; c < obs.size(); c++) begin
      n_checks++;
      if (obs[c] !== 4'b0010) begin
        n_fail++; $display("FAIL idle cycle %0d: got %b want 0010", c, obs[c]);
      end
    end
  endtask

  task automatic test_single_byte();
    bq_t q;
    int  rd_cnt, busy_cnt;
    logic [3:0] exp;
    q.push_back(8'hA5);
    fifo4 = q;
    pops4 = 0;
    capture(0, NB * 4 + 10, -1);
    rd_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < obs.size(); c++) begin
      exp = model_at(q, 4, c);
      rd_cnt += int'(obs[c][3]);
      busy_cnt += int'(obs[c][2]);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++; $display("FAIL single_byte cycle %0d: got %b want %b", c, obs[c], exp);
      end
    end
    n_checks++;
    if (rd_cnt != 1 || pops4 != 1) begin
      n_fail++; $display("FAIL single_pop: rd_en cycles %0d pops %0d want 1 1", rd_cnt, pops4);
    end
    n_checks++;
    if (busy_cnt != NB * 4) begin
      n_fail++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, NB * 4);
    end
  endtask

  task automatic test_back_to_back();
    bq_t q;
    int  first_pop, second_pop;
    logic [3:0] exp;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    fifo4 = q;
    capture(0, 2 * (NB * 4 + 1) + 6, -1);
    first_pop = -1;
    second_pop = -1;
    for (int c = 0; c < obs.size(); c++) begin
      exp = model_at(q, 4, c);
      if (obs[c][3] === 1'b1) begin
        if (first_pop < 0) first_pop = c;
        else if (second_pop < 0) second_pop = c;
      end
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++; $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs[c], exp);
      end
    end
    n_checks++;
    if (second_pop - first_pop != NB * 4 + 1) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", second_pop - first_pop, NB * 4 + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    bq_t q1, q2;
    logic [3:0] exp;
    q1.push_back(8'h3C);
    q2.push_back(8'h5A);
    fifo4.delete();
    fifo4.push_back(8'h3C);
    fifo4.push_back(8'h5A);
    pops4 = 0;
    // cycle 18 lies inside data bit 3 of the first frame
    capture(0, 19 + NB * 4 + 6, 18);
    for (int c = 0; c < obs.size(); c++) begin
      exp = (c <= 18) ? model_at(q1, 4, c) : model_at(q2, 4, c - 19);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++; $display("FAIL reset_mid_frame cycle %0d: got %b want %b", c, obs[c], exp);
      end
    end
    n_checks++;
    if (pops4 != 2 || fifo4.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_pops: pops %0d left %0d want 2 0", pops4, fifo4.size());
    end
  endtask

  task automatic test_cpb1();
    bq_t q;
    logic [3:0] exp;
    q.push_back(8'h55);
    q.push_back(8'h81);
    fifo1 = q;
    pops1 = 0;
    capture(1, 2 * (NB + 1) + 4, -1);
    for (int c = 0; c < obs.size(); c++) begin
      exp = model_at(q, 1, c);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++; $display("FAIL cpb1 cycle %0d: got %b want %b", c, obs[c], exp);
      end
    end
    n_checks++;
    if (pops1 != 2) begin
      n_fail++; $display("FAIL cpb1_pops: got %0d want 2", pops1);
    end
  endtask

  task automatic test_random();
    bq_t q;
    int  sel, n, cpb;
    logic [3:0] exp;
    for (int it = 0; it < 4; it++) begin
      q.delete();
      sel = it % 2;
      cpb = (sel == 0) ? 4 : 1;
      n = $urandom_range(2, 4);
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      if (sel == 0) fifo4 = q; else fifo1 = q;
      capture(sel, n * (NB * cpb + 1) + 5, -1);
      for (int c = 0; c < obs.size(); c++) begin
        exp = model_at(q, cpb, c);
        n_checks++;
        if (obs[c] !== exp) begin
          n_fail++; $display("FAIL random it%0d cycle %0d: got %b want %b", it, c, obs[c], exp);
        end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bq_t q;
    logic [3:0] exp;
    q.push_back(8'h07);
    q.push_back(8'h03);
    fifo4 = q;
    capture(0, 2 * (NB * 4 + 1) + 4, -1);
    for (int c = 0; c < obs.size(); c++) begin
      exp = model_at(q, 4, c);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++; $display("FAIL parity cycle %0d: got %b want %b", c, obs[c], exp);
      end
    end
    n_checks++;
    if (obs[1 + 9 * 4][1] !== 1'b1) begin
      n_fail++; $display("FAIL parity_0x07: got %b want 1", obs[1 + 9 * 4][1]);
    end
    n_checks++;
    if (obs[NB * 4 + 2 + 9 * 4][1] !== 1'b0) begin
      n_fail++; $display("FAIL parity_0x03: got %b want 0", obs[NB * 4 + 2 + 9 * 4][1]);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pend4    = 1'b0;
    pend1    = 1'b0;
    pops4    = 0;
    pops1    = 0;
    rst      = 1'b1;
    drive_fifo();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_cpb1();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
UART transmit engine on the read side of the UART's byte FIFO. Pops one byte whenever the FIFO is non-empty and serializes it as an 8N1 frame on the tx line, LSB first. Bit timing comes from a fixed clock-per-bit divider. The block is the consumer of the FIFO's rd_en / rd_data / empty_flag interface and runs entirely in the FIFO read clock domain.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 1 to 65535
CNT_BITS, $clog2(CLKS_PER_BIT)+1, width of the bit-period counter

Ports:
clk  input  1  single clock; FIFO read clock
rst  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO empty_flag; 1 means no byte is available
fifo_rd_data  input  8  FIFO head byte; valid whenever fifo_empty=0 (show-ahead)
fifo_rd_en  output  1  pop strobe to the FIFO; the pop takes effect at the clk edge where it is high
tx  output  1  serial line; idle high
busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge, the block forces: state=IDLE, tx=1, busy=0, tx_done=0, counters=0, shift register=0.
- fifo_rd_en is combinational: (state==IDLE) && !fifo_empty && !rst. It is never high outside IDLE and never high for two consecutive cycles.
- State IDLE:
  - Drives tx=1 and busy=0.
  - At an edge with fifo_rd_en=1, latch fifo_rd_data into an 8-bit shift register and go to START.
  - The FIFO pops at that same edge.
- State START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- State DATA:
  - tx = shift[0]; each bit is held CLKS_PER_BIT cycles, then the register shifts right and bit_idx increments.
  - After bit_idx=7 completes, go to PARITY if the optional feature is enabled, otherwise STOP.
- State STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 on the last of those cycles; go to IDLE on that edge.
- busy=1 in every state except IDLE. tx and busy are registered, so they have no combinational glitches.
- Bit-period counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on each bit boundary.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Frame timing: 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back frames: there is exactly one IDLE cycle (tx=1) between the end of a stop bit and the next start bit when the FIFO is non-empty. Frame period is 10*CLKS_PER_BIT+1 cycles.
- fifo_empty and fifo_rd_data are ignored outside IDLE. The latched byte is unaffected by FIFO changes mid-frame.
- Reset mid-frame: tx=1 on the next edge and the frame is aborted. The popped byte is lost. No pop happens during reset.
- The FIFO pop pointer is advanced only by fifo_rd_en. The block never pops when fifo_empty=1.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - Adds state PARITY between DATA and STOP.
  - tx = XOR of the 8 latched data bits (even parity), held CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles; back-to-back period becomes 11*CLKS_PER_BIT+1 cycles.
  - Parity is computed from the byte captured at pop, not from the shifted register.
- Undefined: no PARITY state and no parity logic; frame is 8N1 as above.

Test Plan:
- Idle: rst pulse, then fifo_empty=1 for 200 cycles -> tx=1, busy=0, fifo_rd_en=0, tx_done=0 throughout.
- Single byte: CLKS_PER_BIT=4, one byte 0xA5 presented with fifo_empty=0 for one cycle only.
  - fifo_rd_en=1 for exactly 1 cycle.
  - tx sequence per 4-cycle slot: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done pulses on cycle 40 of the frame; busy is high for 40 cycles.
- Back-to-back: CLKS_PER_BIT=4, FIFO holding 0x00 then 0xFF.
  - Two pops, spaced 41 cycles apart.
  - Data slots are all 0s in frame 1 and all 1s in frame 2, with one idle-high cycle between the stop bit and the second start bit.
- Reset mid-frame: rst=1 for 1 cycle during data bit 3 of 0x3C -> next cycle tx=1, busy=0; no extra pop; the next FIFO byte transmits normally afterwards.
- CLKS_PER_BIT=1 with FIFO bytes 0x55 and 0x81 -> frames of 10 cycles each, 11-cycle period; LSB-first bit order checked exactly.
- UART_TX_PARITY_EN defined, CLKS_PER_BIT=4, bytes 0x07 then 0x03 -> parity slot tx=1 for the first byte and 0 for the second; frame 44 cycles; tx_done on cycle 44.
